// File: rtl/axis_src_pkg.sv
// Shared types and constants for the AXI4-Stream pattern source.
// No logic here, only the FSM encoding and TKEEP width helpers.
package axis_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int keep_width(input int data_w);
        return data_w / 8;
    endfunction

    localparam int                DEF_DATA_W = 32;
    localparam int                KEEP_W     = keep_width(DEF_DATA_W);
    localparam logic [KEEP_W-1:0] KEEP_ALL   = '1;

endpackage

// File: rtl/axis_src_beat_ctr.sv
// Beat-in-packet and packet-in-run counters; load latches len/count, advance steps one beat.
// Flags are combinational from registered state, valid the cycle after load and stable until advance.
module axis_src_beat_ctr
    import axis_src_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] count,
    output logic             is_last_beat,
    output logic             is_last_pkt
);

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] beat_idx;
    logic [LEN_W-1:0] pkt_idx;

    // len/count are never zero when loaded, so the minus-one compares cannot underflow in a run.
    assign is_last_beat = (beat_idx == len_q - LEN_W'(1));
    assign is_last_pkt  = (pkt_idx == count_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            count_q  <= '0;
            beat_idx <= '0;
            pkt_idx  <= '0;
        end else if (load) begin
            len_q    <= len;
            count_q  <= count;
            beat_idx <= '0;
            pkt_idx  <= '0;
        end else if (advance) begin
            if (is_last_beat) begin
                beat_idx <= '0;
                pkt_idx  <= pkt_idx + LEN_W'(1);
            end else begin
                beat_idx <= beat_idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/axis_pattern_source.sv
// AXI4-Stream source of incrementing words; first beat one cycle after start; TVALID/TDATA held under TREADY stall.
// Optional inter-packet idle gap of GAP_CYCLES cycles is compiled in with AXIS_SRC_GAP_EN.
module axis_pattern_source
    import axis_src_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  m_axis_clk,
    input  logic                  axis_reset_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [LEN_W-1:0]      pkt_count,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           beats_sent,
    output logic [DATA_W-1:0]     M_AXIS_Src_TDATA,
    output logic [DATA_W/8-1:0]   M_AXIS_Src_TKEEP,
    output logic                  M_AXIS_Src_TLAST,
    output logic                  M_AXIS_Src_TVALID,
    input  logic                  M_AXIS_Src_TREADY
);

    localparam int KW = keep_width(DATA_W);

    state_t state;
    state_t next_state;

    logic              load;
    logic              advance;
    logic              accept;
    logic              start_ok;
    logic              is_last_beat;
    logic              is_last_pkt;
    logic              tvalid_q;
    logic [DATA_W-1:0] tdata_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       beats_q;

    assign accept   = tvalid_q & M_AXIS_Src_TREADY;
    assign start_ok = start && (pkt_len != '0) && (pkt_count != '0);

    axis_src_beat_ctr #(
        .LEN_W (LEN_W)
    ) u_beat_ctr (
        .clk          (m_axis_clk),
        .rst_n        (axis_reset_n),
        .load         (load),
        .advance      (advance),
        .len          (pkt_len),
        .count        (pkt_count),
        .is_last_beat (is_last_beat),
        .is_last_pkt  (is_last_pkt)
    );

`ifdef AXIS_SRC_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_last;

    assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge m_axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge m_axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    next_state = SEND;
                    load       = 1'b1;
                end
            end
            SEND: begin
                if (accept) begin
                    advance = 1'b1;
                    if (is_last_beat) begin
                        if (is_last_pkt) begin
                            next_state = DONE;
                        end
`ifdef AXIS_SRC_GAP_EN
                        else begin
                            next_state = GAP;
                        end
`endif
                    end
                end
            end
`ifdef AXIS_SRC_GAP_EN
            GAP: begin
                if (gap_last) begin
                    next_state = SEND;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status and stream flags are registered from next_state so they line up with the state they describe.
    always_ff @(posedge m_axis_clk or negedge axis_reset_n) begin
        if (!axis_reset_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            beats_q  <= '0;
        end else begin
            tvalid_q <= (next_state == SEND);
            busy_q   <= (next_state == SEND) || (next_state == GAP);
            done_q   <= (next_state == DONE);
            if (load) begin
                tdata_q <= seed;
                beats_q <= '0;
            end else if (accept) begin
                tdata_q <= tdata_q + DATA_W'(1);
                beats_q <= beats_q + 32'd1;
            end
        end
    end

    assign M_AXIS_Src_TVALID = tvalid_q;
    assign M_AXIS_Src_TDATA  = tdata_q;
    assign M_AXIS_Src_TLAST  = tvalid_q & is_last_beat;
    assign M_AXIS_Src_TKEEP  = {KW{1'b1}};
    assign busy              = busy_q;
    assign done              = done_q;
    assign beats_sent        = beats_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed bench for axis_pattern_source: nominal run, stalls, wrap, ignored starts, mid-run reset, optional gap.
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] pkt_count;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic [31:0] beats_sent;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_pattern_source dut (
        .m_axis_clk        (clk),
        .axis_reset_n      (rst_n),
        .start             (start),
        .pkt_len           (pkt_len),
        .pkt_count         (pkt_count),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .beats_sent        (beats_sent),
        .M_AXIS_Src_TDATA  (tdata),
        .M_AXIS_Src_TKEEP  (tkeep),
        .M_AXIS_Src_TLAST  (tlast),
        .M_AXIS_Src_TVALID (tvalid),
        .M_AXIS_Src_TREADY (tready)
    );

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pkt_len = '0; pkt_count = '0; seed = '0; tready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || tdata !== 32'h0 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_stream: got v=%0b d=%h l=%0b expected v=0 d=00000000 l=0", tvalid, tdata, tlast);
        end
        checks++;
        if (tkeep !== 4'hF) begin
            errors++;
            $display("FAIL reset_tkeep: got %h expected f", tkeep);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || beats_sent !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got busy=%0b done=%0b beats=%0d expected 0 0 0", busy, done, beats_sent);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        seed = 32'h10; pkt_len = 16'd4; pkt_count = 16'd2; tready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef AXIS_SRC_GAP_EN
            if (i == 4) begin
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (tvalid !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL basic_gap: got v=%0b busy=%0b expected v=0 busy=1", tvalid, busy);
                    end
                end
            end
`endif
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b1 || tdata !== 32'h10 + i || tlast !== (i % 4 == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: got v=%0b d=%h l=%0b busy=%0b expected v=1 d=%h l=%0b busy=1",
                         i, tvalid, tdata, tlast, busy, 32'h10 + i, (i % 4 == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0 || beats_sent !== 32'd8) begin
            errors++;
            $display("FAIL basic_done: got done=%0b busy=%0b v=%0b beats=%0d expected 1 0 0 8", done, busy, tvalid, beats_sent);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || beats_sent !== 32'd8) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%0b beats=%0d expected 0 8", done, beats_sent);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        logic        held;
        logic [31:0] hd;
        logic        hl;
        int          n;
        int          cyc;
        pat = 16'hB2E4; held = 1'b0; hd = '0; hl = 1'b0; n = 0; cyc = 0;
        @(posedge clk); #1;
        seed = 32'h10; pkt_len = 16'd4; pkt_count = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tready = pat[0];
        while (n < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== hd || tlast !== hl) begin
                    errors++;
                    $display("FAIL bp_stall_stable: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b", tvalid, tdata, tlast, hd, hl);
                end
            end
            held = 1'b0;
            if (tvalid === 1'b1 && tready === 1'b1) begin
                checks++;
                if (tdata !== 32'h10 + n || tlast !== (n % 4 == 3)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got d=%h l=%0b expected d=%h l=%0b", n, tdata, tlast, 32'h10 + n, (n % 4 == 3));
                end
                n++;
            end else if (tvalid === 1'b1) begin
                held = 1'b1; hd = tdata; hl = tlast;
            end
            @(posedge clk); #1;
            tready = pat[cyc % 16];
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_timeout: got %0d beats expected 8", n);
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || beats_sent !== 32'd8) begin
            errors++;
            $display("FAIL bp_done: got done=%0b v=%0b beats=%0d expected 1 0 8", done, tvalid, beats_sent);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hFFFF_FFFE; exp_d[1] = 32'hFFFF_FFFF; exp_d[2] = 32'h0000_0000;
        @(posedge clk); #1;
        seed = 32'hFFFF_FFFE; pkt_len = 16'd3; pkt_count = 16'd1; tready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b1 || tdata !== exp_d[i] || tlast !== (i == 2)) begin
                errors++;
                $display("FAIL wrap_beat%0d: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b", i, tvalid, tdata, tlast, exp_d[i], (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beats_sent !== 32'd3) begin
            errors++;
            $display("FAIL wrap_done: got done=%0b beats=%0d expected 1 3", done, beats_sent);
        end
    endtask

    task automatic test_ignored_start();
        @(posedge clk); #1;
        seed = 32'h77; pkt_len = 16'd0; pkt_count = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beats_sent !== 32'd3) begin
                errors++;
                $display("FAIL zero_len: got v=%0b busy=%0b done=%0b beats=%0d expected 0 0 0 3", tvalid, busy, done, beats_sent);
            end
        end
        @(posedge clk); #1;
        pkt_len = 16'd2; pkt_count = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || beats_sent !== 32'd3) begin
            errors++;
            $display("FAIL zero_count: got v=%0b busy=%0b beats=%0d expected 0 0 3", tvalid, busy, beats_sent);
        end
        @(posedge clk); #1;
        seed = 32'h100; pkt_len = 16'd4; pkt_count = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed = 32'h900; pkt_len = 16'd1; pkt_count = 16'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = (i == 1);
            checks++;
            if (tvalid !== 1'b1 || tdata !== 32'h100 + i || tlast !== (i == 3)) begin
                errors++;
                $display("FAIL busy_start_beat%0d: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b", i, tvalid, tdata, tlast, 32'h100 + i, (i == 3));
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beats_sent !== 32'd4) begin
            errors++;
            $display("FAIL busy_start_done: got done=%0b beats=%0d expected 1 4", done, beats_sent);
        end
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got v=%0b busy=%0b expected 0 0", tvalid, busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        @(posedge clk); #1;
        seed = 32'h55; pkt_len = 16'd4; pkt_count = 16'd1; tready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'h55) begin
            errors++;
            $display("FAIL rst_mid_stalled: got v=%0b d=%h expected v=1 d=00000055", tvalid, tdata);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: got v=%0b busy=%0b l=%0b expected 0 0 0", tvalid, busy, tlast);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got v=%0b busy=%0b done=%0b expected 0 0 0", tvalid, busy, done);
        end
        @(posedge clk); #1;
        seed = 32'hA0; pkt_len = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== 1'b1 || tdata !== 32'hA0 + i || tlast !== (i == 1)) begin
                errors++;
                $display("FAIL rst_rerun_beat%0d: got v=%0b d=%h l=%0b expected v=1 d=%h l=%0b", i, tvalid, tdata, tlast, 32'hA0 + i, (i == 1));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || beats_sent !== 32'd2) begin
            errors++;
            $display("FAIL rst_rerun_done: got done=%0b beats=%0d expected 1 2", done, beats_sent);
        end
    endtask

`ifdef AXIS_SRC_GAP_EN
    task automatic test_gap();
        @(posedge clk); #1;
        seed = 32'h20; pkt_len = 16'd2; pkt_count = 16'd3; tready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Each packet slot is 2 beats then 4 idle cycles; the final packet has no trailing idle.
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (tvalid !== ((c % 6) < 2) || busy !== 1'b1 ||
                ((c % 6) < 2 && (tdata !== 32'h20 + (c / 6) * 2 + (c % 6) || tlast !== ((c % 6) == 1)))) begin
                errors++;
                $display("FAIL gap_cycle%0d: got v=%0b d=%h l=%0b busy=%0b expected v=%0b d=%h", c, tvalid, tdata, tlast, busy,
                         ((c % 6) < 2), 32'h20 + (c / 6) * 2 + (c % 6));
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || beats_sent !== 32'd6) begin
            errors++;
            $display("FAIL gap_done: got done=%0b v=%0b beats=%0d expected 1 0 6", done, tvalid, beats_sent);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ignored_start();
        test_reset_mid_packet();
`ifdef AXIS_SRC_GAP_EN
        test_gap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
